// File: rtl/data_memory_sized.sv
// data_memory_sized
//   Byte-addressable data memory with byte / half / word loads and stores,
//   alignment and range checking, and a configurable read latency.
//   A small three-state controller (IDLE, BUSY, DONE) sequences each
//   transaction and raises a one-cycle done pulse when it completes.
//
// Parameters
//   DATA_WIDTH   : word width in bits, a multiple of 32
//   MEMORY_DEPTH : number of words
//   BASE_ADDR    : byte address of word 0
//   READ_LATENCY : cycles from load acceptance to done_o, 1..4
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous active-high reset
//   req_i        : transaction request, accepted when ready_o is high
//   ready_o      : block can accept a request this cycle (IDLE or DONE)
//   we_i         : 1 = store, 0 = load
//   size_i       : 00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i   : loads zero-extend when 1, sign-extend when 0
//   address_i    : byte address
//   write_data_i : store data, right-aligned
//   read_data_o  : load result, right-aligned and extended
//   done_o       : one-cycle completion pulse
//   error_o      : qualifies done_o, the transaction faulted

module data_memory_sized #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR    = 32'h10010000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  output logic                  ready_o,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [31:0]           address_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      latCount_q;
  logic [CNT_W-1:0]      latCount_d;
  logic [DATA_WIDTH-1:0] readData_q;
  logic [DATA_WIDTH-1:0] pendingData_q;
  logic                  error_q;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic                  accept;
  logic [31:0]           relAddr;
  logic [31:0]           wordIndex;
  logic [OFF_W-1:0]      offset;
  logic [IDX_W-1:0]      memIdx;
  logic                  misaligned;
  logic                  outOfRange;
  logic                  fault;
  logic                  memWrite;
  logic [BYTES-1:0]      byteEn;
  logic [DATA_WIDTH-1:0] wrData;
  logic [DATA_WIDTH-1:0] rawWord;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] loadValue;

  assign ready_o     = (state_q != BUSY);
  assign done_o      = (state_q == DONE);
  assign error_o     = error_q;
  assign read_data_o = readData_q;

  assign accept     = req_i && ready_o;
  assign latCount_d = latCount_q - 1'b1;

  // Addresses are made relative to BASE_ADDR first; an address below the
  // base wraps to a huge index, but it is also rejected explicitly.
  assign relAddr    = address_i - BASE_ADDR;
  assign wordIndex  = relAddr >> OFF_W;
  assign offset     = relAddr[OFF_W-1:0];
  assign memIdx     = wordIndex[IDX_W-1:0];
  assign outOfRange = (address_i < BASE_ADDR) || (wordIndex >= 32'(MEMORY_DEPTH));
  assign fault      = (size_i == 2'b11) || misaligned || outOfRange;
  assign memWrite   = !reset && accept && we_i && !fault;

  // Halves must sit on an even byte, full words on lane 0.
  always_comb begin
    misaligned = 1'b0;
    case (size_i)
      2'b01:   misaligned = offset[0];
      2'b10:   misaligned = (offset != '0);
      default: misaligned = 1'b0;
    endcase
  end

  // Store data is replicated across every lane so that the byte enables
  // alone decide which lanes are written.
  always_comb begin
    byteEn = '0;
    wrData = write_data_i;
    case (size_i)
      2'b00: begin
        byteEn = BYTES'(1) << offset;
        wrData = {BYTES{write_data_i[7:0]}};
      end
      2'b01: begin
        byteEn = BYTES'(3) << offset;
        wrData = {(BYTES / 2){write_data_i[15:0]}};
      end
      2'b10:   byteEn = '1;
      default: byteEn = '0;
    endcase
  end

  // Storage array: never reset or initialised, only addressed lanes change.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byteEn[b]) begin
          mem[memIdx][b*8 +: 8] <= wrData[b*8 +: 8];
        end
      end
    end
  end

  // Load path: select the addressed lanes and extend them to full width.
  always_comb begin
    rawWord   = mem[memIdx];
    shifted   = rawWord >> {offset, 3'b000};
    loadValue = shifted;
    case (size_i)
      2'b00:   loadValue = {{(DATA_WIDTH - 8){!unsigned_i && shifted[7]}}, shifted[7:0]};
      2'b01:   loadValue = {{(DATA_WIDTH - 16){!unsigned_i && shifted[15]}}, shifted[15:0]};
      default: loadValue = shifted;
    endcase
  end

  // Transaction controller. Load data is captured at the acceptance edge;
  // with a multi-cycle latency it waits in pendingData_q so read_data_o
  // keeps the previous result until the new load reaches DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      latCount_q    <= '0;
      readData_q    <= '0;
      pendingData_q <= '0;
      error_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (fault) begin
              state_q    <= DONE;
              error_q    <= 1'b1;
              readData_q <= '0;
            end else if (we_i) begin
              state_q    <= DONE;
              error_q    <= 1'b0;
              readData_q <= '0;
            end else if (READ_LATENCY <= 1) begin
              state_q    <= DONE;
              error_q    <= 1'b0;
              readData_q <= loadValue;
            end else begin
              state_q       <= BUSY;
              error_q       <= 1'b0;
              latCount_q    <= LAT_INIT;
              pendingData_q <= loadValue;
            end
          end else begin
            state_q <= IDLE;
            error_q <= 1'b0;
          end
        end
        BUSY: begin
          latCount_q <= latCount_d;
          if (latCount_d == '0) begin
            state_q    <= DONE;
            readData_q <= pendingData_q;
          end
        end
        default: begin
          state_q    <= IDLE;
          latCount_q <= '0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized
//   Directed testbench for data_memory_sized with READ_LATENCY = 3.
//   Stimulus pushes the hand-computed response of each request into a
//   queue; an independent monitor pops and compares whenever done_o is seen.

module tb_data_memory_sized;

  localparam int LAT = 3;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cycle;
    int          id;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_i;
  logic        ready_o;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        done_o;
  logic        error_o;

  exp_t expQ[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cycleCnt = 0;
  int   txnId    = 0;

  data_memory_sized #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(64),
    .BASE_ADDR   (32'h10010000),
    .READ_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .ready_o     (ready_o),
    .we_i        (we_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .address_i   (address_i),
    .write_data_i(write_data_i),
    .read_data_o (read_data_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request on the first cycle ready_o is high and record the
  // response and the cycle in which done_o must appear.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr);
    int   waitCycles;
    exp_t e;
    logic loadOk;
    @(negedge clk);
    waitCycles = 0;
    while (ready_o !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput($sformatf("txn %0d ready before issue", txnId), 32'(ready_o), 32'd1);
    loadOk       = !we && !expErr;
    we_i         = we;
    size_i       = size;
    unsigned_i   = uns;
    address_i    = addr;
    write_data_i = wdata;
    req_i        = 1'b1;
    e.data  = expData;
    e.err   = expErr;
    e.cycle = cycleCnt + (loadOk ? LAT : 1);
    e.id    = txnId;
    expQ.push_back(e);
    txnId++;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    we_i  = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("txn %0d ready after accept", e.id), 32'(ready_o),
                (loadOk && LAT > 1) ? 32'd0 : 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ready"}, 32'(ready_o), 32'd1);
    checkOutput({tag, " done"}, 32'(done_o), 32'd0);
    checkOutput({tag, " error"}, 32'(error_o), 32'd0);
    checkOutput({tag, " read_data"}, read_data_o, 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", 32'(done_o), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("txn %0d data", e.id), read_data_o, e.data);
          checkOutput($sformatf("txn %0d error", e.id), 32'(error_o), 32'(e.err));
          checkOutput($sformatf("txn %0d done cycle", e.id), 32'(cycleCnt), 32'(e.cycle));
          checkOutput($sformatf("txn %0d ready in done", e.id), 32'(ready_o), 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int drainWait;
    reset        = 1'b1;
    req_i        = 1'b0;
    we_i         = 1'b0;
    size_i       = SZ_W;
    unsigned_i   = 1'b0;
    address_i    = 32'h0;
    write_data_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("initial reset");
    reset = 1'b0;

    // Known contents for the first and last words and the test word.
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h10010000, 32'h11111111, 32'h0, 1'b0);
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h100100FC, 32'h63636363, 32'h0, 1'b0);
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h10010008, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010008, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store only touches lane 1.
    applyStimulus(1'b1, SZ_B, 1'b0, 32'h10010009, 32'h12345680, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_B, 1'b0, 32'h10010009, 32'h0, 32'hFFFFFF80, 1'b0);
    applyStimulus(1'b0, SZ_B, 1'b1, 32'h10010009, 32'h0, 32'h00000080, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010008, 32'h0, 32'hDEAD80EF, 1'b0);

    // Half-word loads and a half store into the upper lanes.
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h1001000A, 32'h0, 32'hFFFFDEAD, 1'b0);
    applyStimulus(1'b0, SZ_H, 1'b1, 32'h1001000A, 32'h0, 32'h0000DEAD, 1'b0);
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h10010008, 32'h0, 32'hFFFF80EF, 1'b0);
    applyStimulus(1'b1, SZ_H, 1'b0, 32'h1001000A, 32'hAAAA7FFF, 32'h0, 1'b0);
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h1001000A, 32'h0, 32'h00007FFF, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010008, 32'h0, 32'h7FFF80EF, 1'b0);

    // Faulted requests: misalignment, illegal size, out of range.
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h10010003, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010002, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, SZ_X, 1'b0, 32'h10010008, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h10010002, 32'hFFFFFFFF, 32'h0, 1'b1);
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h1000FFFC, 32'hFFFFFFFF, 32'h0, 1'b1);
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h10010100, 32'hFFFFFFFF, 32'h0, 1'b1);
    applyStimulus(1'b0, SZ_B, 1'b1, 32'h10010100, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, SZ_X, 1'b0, 32'h10010008, 32'hFFFFFFFF, 32'h0, 1'b1);

    // Faulted stores left memory alone; these loads run back to back.
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010000, 32'h0, 32'h11111111, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h100100FC, 32'h0, 32'h63636363, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010008, 32'h0, 32'h7FFF80EF, 1'b0);
    applyStimulus(1'b0, SZ_B, 1'b1, 32'h100100FF, 32'h0, 32'h00000063, 1'b0);
    applyStimulus(1'b0, SZ_B, 1'b0, 32'h1001000B, 32'h0, 32'h0000007F, 1'b0);
    applyStimulus(1'b0, SZ_H, 1'b1, 32'h10010008, 32'h0, 32'h000080EF, 1'b0);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010000, 32'h0, 32'h11111111, 1'b0);

    // Reset while a load is in BUSY: the load is dropped, no done follows.
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010008, 32'h0, 32'h7FFF80EF, 1'b0);
    reset = 1'b1;
    void'(expQ.pop_back());
    @(posedge clk);
    @(negedge clk);
    checkResetState("reset in busy");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("idle after abort ready", 32'(ready_o), 32'd1);

    // A store presented together with reset is discarded.
    reset        = 1'b1;
    req_i        = 1'b1;
    we_i         = 1'b1;
    size_i       = SZ_W;
    address_i    = 32'h10010000;
    write_data_i = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    checkResetState("reset with store");
    reset = 1'b0;
    req_i = 1'b0;
    we_i  = 1'b0;
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h10010000, 32'h0, 32'h11111111, 1'b0);

    drainWait = 0;
    while (expQ.size() != 0 && drainWait < 40) begin
      @(negedge clk);
      drainWait++;
    end
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
